// File: rtl/conecta4_pkg.sv
// Shared definitions for the Connect-4 piece inserter.
// Holds the board size, the cell codes, the board and FSM types, and the
// column-pulse priority helper.
package conecta4_pkg;

    localparam int unsigned FILAS    = 6;
    localparam int unsigned COLUMNAS = 7;

    localparam logic [1:0] VACIO     = 2'b00;
    localparam logic [1:0] JUGADOR_1 = 2'b01;
    localparam logic [1:0] JUGADOR_2 = 2'b10;

    typedef logic [1:0] celda_t;
    typedef celda_t tablero_t [FILAS][COLUMNAS];

    typedef enum logic [2:0] {
        ESPERA,
        BUSCAR,
        ESCRIBIR,
        VERIFICAR,
        FIN
    } estado_t;

    // Index of the lowest set bit of a 7-bit pulse vector (0 when empty).
    function automatic logic [2:0] primer_bit(input logic [6:0] v);
        primer_bit = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (v[i]) begin
                primer_bit = 3'(i);
            end
        end
    endfunction

endpackage

// File: rtl/verificador_cuatro.sv
// Combinational four-in-a-row detector for the cell just written.
// Ports:
//   tablero  - current board (row 0 is the top row)
//   fila     - row of the placed cell
//   columna  - column of the placed cell
//   jugador  - code of the player that placed it
//   gana     - high when a run of four or more passes through that cell
module verificador_cuatro #(
    parameter int unsigned FILAS    = conecta4_pkg::FILAS,
    parameter int unsigned COLUMNAS = conecta4_pkg::COLUMNAS
) (
    input  logic [1:0]                    tablero [FILAS][COLUMNAS],
    input  logic [$clog2(FILAS)-1:0]      fila,
    input  logic [$clog2(COLUMNAS)-1:0]   columna,
    input  logic [1:0]                    jugador,
    output logic                          gana
);

    localparam int unsigned ROW_W = $clog2(FILAS);
    localparam int unsigned COL_W = $clog2(COLUMNAS);

    // For each axis walk up to three cells each way from the placed cell,
    // stopping at the first non-matching or off-board cell.
    always_comb begin
        int   cuenta;
        int   f;
        int   c;
        int   df;
        int   dc;
        logic seguir;
        gana   = 1'b0;
        cuenta = 0;
        f      = 0;
        c      = 0;
        seguir = 1'b0;
        for (int d = 0; d < 4; d++) begin
            // d: 0 horizontal, 1 vertical, 2 down-right diagonal, 3 down-left diagonal
            df     = (d == 0) ? 0 : 1;
            dc     = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
            cuenta = 1;
            for (int s = -1; s <= 1; s += 2) begin
                seguir = 1'b1;
                for (int p = 1; p <= 3; p++) begin
                    f = int'(fila) + s * p * df;
                    c = int'(columna) + s * p * dc;
                    if (seguir && (f >= 0) && (f < int'(FILAS)) &&
                        (c >= 0) && (c < int'(COLUMNAS)) &&
                        (tablero[ROW_W'(f)][COL_W'(c)] == jugador)) begin
                        cuenta = cuenta + 1;
                    end else begin
                        seguir = 1'b0;
                    end
                end
            end
            if (cuenta >= 4) begin
                gana = 1'b1;
            end
        end
    end

endmodule

// File: rtl/insertor_ficha.sv
// Connect-4 piece inserter: accepts a column request, drops the current
// player's piece to the lowest free row, checks for a win or draw and
// hands the turn over.
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   enable            - controller is in its move state
//   limpiar           - synchronous new-game clear
//   pulsos_jugador    - one-cycle column pulses from buttons (priority)
//   pulsos_random     - one-cycle column pulses from the random timer
//   tablero           - registered board (00 empty, 01 P1, 10 P2)
//   jugador_actual    - player to move
//   movimiento_hecho  - one-cycle pulse when a piece is placed
//   columna_llena     - one-cycle pulse when the requested column is full
//   ganador           - winning player code, 00 while none
//   empate            - board full with no winner
//   ocupado           - high whenever the FSM is not idle
module insertor_ficha
    import conecta4_pkg::*;
#(
    parameter int unsigned FILAS    = conecta4_pkg::FILAS,
    parameter int unsigned COLUMNAS = conecta4_pkg::COLUMNAS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       limpiar,
    input  logic [6:0] pulsos_jugador,
    input  logic [6:0] pulsos_random,
    output logic [1:0] tablero [FILAS][COLUMNAS],
    output logic [1:0] jugador_actual,
    output logic       movimiento_hecho,
    output logic       columna_llena,
    output logic [1:0] ganador,
    output logic       empate,
    output logic       ocupado
);

    localparam int unsigned ROW_W = $clog2(FILAS);
    localparam int unsigned COL_W = $clog2(COLUMNAS);
    localparam logic [5:0]  TOTAL = 6'(FILAS * COLUMNAS);

    estado_t            estado_q;
    logic [1:0]         tablero_q [FILAS][COLUMNAS];
    logic [1:0]         jugador_q;
    logic [1:0]         ganador_q;
    logic               empate_q;
    logic               mov_q;
    logic               llena_q;
    logic               ocupado_q;
    logic [5:0]         cuenta_q;
    logic [ROW_W-1:0]   ptr_q;
    logic [ROW_W-1:0]   fila_q;
    logic [COL_W-1:0]   col_q;

    logic [6:0]         pulsos_sel_c;
    logic [COL_W-1:0]   col_sel_c;
    logic               gana_c;

    // Button pulses win over timer pulses; lowest index wins inside a vector.
    assign pulsos_sel_c = (pulsos_jugador != 7'd0) ? pulsos_jugador : pulsos_random;
    assign col_sel_c    = COL_W'(primer_bit(pulsos_sel_c));

    verificador_cuatro #(
        .FILAS    (FILAS),
        .COLUMNAS (COLUMNAS)
    ) u_verificador (
        .tablero (tablero_q),
        .fila    (fila_q),
        .columna (col_q),
        .jugador (jugador_q),
        .gana    (gana_c)
    );

    // Move sequencer: search column bottom-up, write, then evaluate the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= ESPERA;
            for (int r = 0; r < int'(FILAS); r++) begin
                for (int c = 0; c < int'(COLUMNAS); c++) begin
                    tablero_q[r][c] <= VACIO;
                end
            end
            jugador_q <= JUGADOR_1;
            ganador_q <= VACIO;
            empate_q  <= 1'b0;
            mov_q     <= 1'b0;
            llena_q   <= 1'b0;
            ocupado_q <= 1'b0;
            cuenta_q  <= 6'd0;
            ptr_q     <= '0;
            fila_q    <= '0;
            col_q     <= '0;
        end else if (limpiar) begin
            estado_q  <= ESPERA;
            for (int r = 0; r < int'(FILAS); r++) begin
                for (int c = 0; c < int'(COLUMNAS); c++) begin
                    tablero_q[r][c] <= VACIO;
                end
            end
            jugador_q <= JUGADOR_1;
            ganador_q <= VACIO;
            empate_q  <= 1'b0;
            mov_q     <= 1'b0;
            llena_q   <= 1'b0;
            ocupado_q <= 1'b0;
            cuenta_q  <= 6'd0;
            ptr_q     <= '0;
            fila_q    <= '0;
            col_q     <= '0;
        end else begin
            mov_q   <= 1'b0;
            llena_q <= 1'b0;
            case (estado_q)
                ESPERA: begin
                    if (enable && (pulsos_sel_c != 7'd0)) begin
                        col_q     <= col_sel_c;
                        ptr_q     <= ROW_W'(FILAS - 1);
                        estado_q  <= BUSCAR;
                        ocupado_q <= 1'b1;
                    end
                end
                BUSCAR: begin
                    if (tablero_q[ptr_q][col_q] == VACIO) begin
                        fila_q   <= ptr_q;
                        estado_q <= ESCRIBIR;
                    end else if (ptr_q == '0) begin
                        llena_q   <= 1'b1;
                        estado_q  <= ESPERA;
                        ocupado_q <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q - ROW_W'(1);
                    end
                end
                ESCRIBIR: begin
                    tablero_q[fila_q][col_q] <= jugador_q;
                    estado_q                 <= VERIFICAR;
                end
                VERIFICAR: begin
                    mov_q     <= 1'b1;
                    cuenta_q  <= cuenta_q + 6'd1;
                    ganador_q <= gana_c ? jugador_q : VACIO;
                    if (gana_c) begin
                        estado_q <= FIN;
                    end else if ((cuenta_q + 6'd1) == TOTAL) begin
                        empate_q <= 1'b1;
                        estado_q <= FIN;
                    end else begin
                        jugador_q <= (jugador_q == JUGADOR_1) ? JUGADOR_2 : JUGADOR_1;
                        estado_q  <= ESPERA;
                        ocupado_q <= 1'b0;
                    end
                end
                FIN: begin
                    estado_q <= FIN;
                end
                default: begin
                    estado_q  <= ESPERA;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign tablero          = tablero_q;
    assign jugador_actual   = jugador_q;
    assign movimiento_hecho = mov_q;
    assign columna_llena    = llena_q;
    assign ganador          = ganador_q;
    assign empate           = empate_q;
    assign ocupado          = ocupado_q;

endmodule

// File: tb/tb_insertor_ficha.sv
// Self-checking bench for insertor_ficha: directed scenarios plus a random
// move stream compared against a board-level Connect-4 reference model.
module tb_insertor_ficha;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       limpiar;
    logic [6:0] pulsos_jugador;
    logic [6:0] pulsos_random;
    conecta4_pkg::tablero_t tablero;
    logic [1:0] jugador_actual;
    logic       movimiento_hecho;
    logic       columna_llena;
    logic [1:0] ganador;
    logic       empate;
    logic       ocupado;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain game state.
    int mb [6][7];
    int m_jug;
    int m_moves;
    int m_gan;
    bit m_emp;
    bit m_fin;

    always #5 clk = ~clk;

    insertor_ficha #(.FILAS(6), .COLUMNAS(7)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .limpiar          (limpiar),
        .pulsos_jugador   (pulsos_jugador),
        .pulsos_random    (pulsos_random),
        .tablero          (tablero),
        .jugador_actual   (jugador_actual),
        .movimiento_hecho (movimiento_hecho),
        .columna_llena    (columna_llena),
        .ganador          (ganador),
        .empate           (empate),
        .ocupado          (ocupado)
    );

    function automatic void model_reset();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                mb[r][c] = 0;
        m_jug = 1; m_moves = 0; m_gan = 0; m_emp = 1'b0; m_fin = 1'b0;
    endfunction

    // Brute-force scan of every 4-cell window on the board.
    function automatic bit model_cuatro(input int p);
        int dr [4] = '{0, 1, 1, 1};
        int dc [4] = '{1, 0, 1, -1};
        bit ok;
        int rr;
        int cc;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                for (int d = 0; d < 4; d++) begin
                    ok = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        rr = r + i * dr[d];
                        cc = c + i * dc[d];
                        if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 1'b0;
                        else if (mb[rr][cc] != p) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    // res: 0 placed, 1 column full, 2 ignored (game over); k = pieces already in column.
    function automatic void model_play(input int col, output int k, output int res);
        k = 0; res = 2;
        if (m_fin) return;
        for (int r = 0; r < 6; r++) if (mb[r][col] != 0) k++;
        if (k == 6) begin res = 1; return; end
        res = 0;
        mb[5 - k][col] = m_jug;
        m_moves++;
        if (model_cuatro(m_jug)) begin m_gan = m_jug; m_fin = 1'b1; end
        else if (m_moves == 42) begin m_emp = 1'b1; m_fin = 1'b1; end
        else m_jug = 3 - m_jug;
    endfunction

    function automatic int sel_col(input logic [6:0] pj, input logic [6:0] pr);
        logic [6:0] v;
        v = (pj != 7'd0) ? pj : pr;
        for (int i = 0; i < 7; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int board_diffs();
        int d = 0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                if (tablero[r][c] !== 2'(mb[r][c])) d++;
        return d;
    endfunction

    function automatic logic [6:0] onehot(input int c);
        return 7'(32'd1 << c);
    endfunction

    // Pulse for one cycle, then report the cycle (relative to the sampling edge) of each result pulse.
    task automatic jugada(input logic [6:0] pj, input logic [6:0] pr,
                          output int n_mov, output int n_llena, output bit solape);
        n_mov = -1; n_llena = -1; solape = 1'b0;
        @(negedge clk);
        pulsos_jugador = pj; pulsos_random = pr;
        @(posedge clk);
        @(negedge clk);
        pulsos_jugador = 7'd0; pulsos_random = 7'd0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (movimiento_hecho && columna_llena) solape = 1'b1;
            if (movimiento_hecho && n_mov < 0) n_mov = n;
            if (columna_llena && n_llena < 0) n_llena = n;
            if (n_mov >= 0 || n_llena >= 0) break;
        end
    endtask

    task automatic do_limpiar();
        @(negedge clk); limpiar = 1'b1;
        @(negedge clk); limpiar = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; limpiar = 1'b0;
        pulsos_jugador = 7'd0; pulsos_random = 7'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        n_tests++; if (board_diffs() !== 0) begin n_fail++; $display("FAIL reset_board: %0d cells differ from empty", board_diffs()); end
        n_tests++; if (jugador_actual !== 2'b01) begin n_fail++; $display("FAIL reset_jugador: got %b expected 01", jugador_actual); end
        n_tests++; if (ganador !== 2'b00) begin n_fail++; $display("FAIL reset_ganador: got %b expected 00", ganador); end
        n_tests++; if ({empate, movimiento_hecho, columna_llena, ocupado} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {empate, movimiento_hecho, columna_llena, ocupado}); end
    endtask

    task automatic test_single_drop();
        int nm, nl, k, res; bit so;
        model_play(sel_col(7'b0000100, 7'd0), k, res);
        jugada(7'b0000100, 7'd0, nm, nl, so);
        n_tests++; if (nm !== 3) begin n_fail++; $display("FAIL drop_latency: got %0d expected 3", nm); end
        n_tests++; if (tablero[5][2] !== 2'b01) begin n_fail++; $display("FAIL drop_cell: got %b expected 01", tablero[5][2]); end
        n_tests++; if (jugador_actual !== 2'b10) begin n_fail++; $display("FAIL drop_turn: got %b expected 10", jugador_actual); end
        n_tests++; if (board_diffs() !== 0) begin n_fail++; $display("FAIL drop_board: %0d cells differ", board_diffs()); end
    endtask

    task automatic test_priority();
        int nm, nl, k, res; bit so;
        model_play(sel_col(7'b0001000, 7'b0000010), k, res);
        jugada(7'b0001000, 7'b0000010, nm, nl, so);
        n_tests++; if (tablero[5][3] !== 2'b10) begin n_fail++; $display("FAIL prio_cell: got %b expected 10", tablero[5][3]); end
        n_tests++; if (tablero[5][1] !== 2'b00) begin n_fail++; $display("FAIL prio_other: got %b expected 00", tablero[5][1]); end
        n_tests++; if (nm !== 3) begin n_fail++; $display("FAIL prio_latency: got %0d expected 3", nm); end
    endtask

    task automatic test_full_column();
        int nm, nl, k, res; bit so;
        do_limpiar();
        for (int i = 0; i < 6; i++) begin
            model_play(0, k, res);
            jugada(7'd0, 7'b0000001, nm, nl, so);
            n_tests++; if (nm !== 3 + i) begin n_fail++; $display("FAIL fill_latency[%0d]: got %0d expected %0d", i, nm, 3 + i); end
        end
        model_play(0, k, res);
        jugada(7'd0, 7'b0000001, nm, nl, so);
        n_tests++; if (nl !== 6) begin n_fail++; $display("FAIL full_latency: got %0d expected 6", nl); end
        n_tests++; if (nm !== -1) begin n_fail++; $display("FAIL full_no_move: got %0d expected -1", nm); end
        n_tests++; if (board_diffs() !== 0) begin n_fail++; $display("FAIL full_board: %0d cells differ", board_diffs()); end
        n_tests++; if (jugador_actual !== 2'b01) begin n_fail++; $display("FAIL full_turn: got %b expected 01", jugador_actual); end
    endtask

    task automatic test_ignored();
        int nm, nl, k, res, movs; bit so;
        enable = 1'b0;
        jugada(7'b0000100, 7'd0, nm, nl, so);
        enable = 1'b1;
        n_tests++; if (nm !== -1 || nl !== -1) begin n_fail++; $display("FAIL disabled_pulse: got mov=%0d llena=%0d expected -1/-1", nm, nl); end
        n_tests++; if (board_diffs() !== 0) begin n_fail++; $display("FAIL disabled_board: %0d cells differ", board_diffs()); end
        // Second pulse while busy must be dropped; enable falls mid-move.
        model_play(1, k, res);
        movs = 0;
        @(negedge clk); pulsos_jugador = 7'b0000010;
        @(posedge clk);
        @(negedge clk); pulsos_jugador = 7'd0; pulsos_random = 7'b0010000;
        @(negedge clk); pulsos_random = 7'd0; enable = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (movimiento_hecho) movs++;
        end
        enable = 1'b1;
        n_tests++; if (movs !== 1) begin n_fail++; $display("FAIL busy_moves: got %0d expected 1", movs); end
        n_tests++; if (board_diffs() !== 0) begin n_fail++; $display("FAIL busy_board: %0d cells differ", board_diffs()); end
        n_tests++; if (jugador_actual !== 2'(m_jug)) begin n_fail++; $display("FAIL busy_turn: got %b expected %0d", jugador_actual, m_jug); end
    endtask

    task automatic test_win_and_clear();
        int seq [7] = '{0, 6, 1, 6, 2, 6, 3};
        int nm, nl, k, res; bit so;
        do_limpiar();
        for (int i = 0; i < 7; i++) begin
            model_play(seq[i], k, res);
            jugada(onehot(seq[i]), 7'd0, nm, nl, so);
        end
        n_tests++; if (ganador !== 2'b01) begin n_fail++; $display("FAIL win_ganador: got %b expected 01", ganador); end
        n_tests++; if (ocupado !== 1'b1 || empate !== 1'b0) begin n_fail++; $display("FAIL win_state: got ocupado=%b empate=%b expected 1/0", ocupado, empate); end
        n_tests++; if (board_diffs() !== 0) begin n_fail++; $display("FAIL win_board: %0d cells differ", board_diffs()); end
        model_play(4, k, res);
        jugada(7'b0010000, 7'b0000001, nm, nl, so);
        n_tests++; if (nm !== -1 || nl !== -1 || board_diffs() !== 0) begin n_fail++; $display("FAIL fin_ignores: got mov=%0d llena=%0d diffs=%0d expected -1/-1/0", nm, nl, board_diffs()); end
        do_limpiar(); #1;
        n_tests++; if (board_diffs() !== 0) begin n_fail++; $display("FAIL clear_board: %0d cells differ", board_diffs()); end
        n_tests++; if (jugador_actual !== 2'b01 || ganador !== 2'b00 || ocupado !== 1'b0) begin n_fail++; $display("FAIL clear_regs: got jug=%b gan=%b ocu=%b expected 01/00/0", jugador_actual, ganador, ocupado); end
    endtask

    task automatic test_draw();
        int a_cols [3] = '{0, 1, 4};
        int b_cols [3] = '{2, 3, 6};
        int orden [$];
        int nm, nl, k, res, bad; bit so;
        do_limpiar();
        for (int p = 0; p < 3; p++)
            for (int j = 0; j < 3; j++) begin
                orden.push_back(a_cols[p]); orden.push_back(b_cols[p]);
                orden.push_back(b_cols[p]); orden.push_back(a_cols[p]);
            end
        for (int j = 0; j < 6; j++) orden.push_back(5);
        bad = 0;
        foreach (orden[i]) begin
            model_play(orden[i], k, res);
            jugada(7'd0, onehot(orden[i]), nm, nl, so);
            if (nm !== 3 + k) bad++;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL draw_latency: %0d moves with wrong latency", bad); end
        n_tests++; if (empate !== 1'b1) begin n_fail++; $display("FAIL draw_empate: got %b expected 1", empate); end
        n_tests++; if (ganador !== 2'b00) begin n_fail++; $display("FAIL draw_ganador: got %b expected 00", ganador); end
        n_tests++; if (board_diffs() !== 0 || ocupado !== 1'b1) begin n_fail++; $display("FAIL draw_board: diffs=%0d ocupado=%b expected 0/1", board_diffs(), ocupado); end
    endtask

    task automatic test_reset_mid_move();
        int nm, nl, k, res, movs; bit so;
        do_limpiar();
        model_play(0, k, res);
        jugada(7'b0000001, 7'd0, nm, nl, so);
        @(negedge clk); pulsos_jugador = 7'b0000100;
        @(posedge clk);
        @(negedge clk); pulsos_jugador = 7'd0; reset = 1'b1;
        model_reset();
        #1;
        n_tests++; if (board_diffs() !== 0) begin n_fail++; $display("FAIL midreset_board: %0d cells differ", board_diffs()); end
        n_tests++; if (jugador_actual !== 2'b01 || ganador !== 2'b00 || ocupado !== 1'b0 || movimiento_hecho !== 1'b0) begin n_fail++; $display("FAIL midreset_regs: got jug=%b gan=%b ocu=%b mov=%b expected 01/00/0/0", jugador_actual, ganador, ocupado, movimiento_hecho); end
        @(negedge clk); reset = 1'b0;
        movs = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (movimiento_hecho || columna_llena) movs++;
        end
        n_tests++; if (movs !== 0 || board_diffs() !== 0) begin n_fail++; $display("FAIL midreset_after: pulses=%0d diffs=%0d expected 0/0", movs, board_diffs()); end
    endtask

    task automatic test_random();
        int nm, nl, k, res, mode, exp_m, exp_l; bit so;
        logic [6:0] pj, pr;
        do_limpiar();
        for (int it = 0; it < 80; it++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin pj = 7'd0; pr = onehot($urandom_range(0, 6)); end
                1: begin pj = onehot($urandom_range(0, 6)); pr = 7'($urandom_range(0, 127)); end
                2: begin pj = 7'($urandom_range(1, 127)); pr = 7'd0; end
                default: begin pj = onehot($urandom_range(0, 6)); pr = 7'd0; end
            endcase
            model_play(sel_col(pj, pr), k, res);
            exp_m = (res == 0) ? 3 + k : -1;
            exp_l = (res == 1) ? 6 : -1;
            jugada(pj, pr, nm, nl, so);
            n_tests++; if (nm !== exp_m || nl !== exp_l) begin n_fail++; $display("FAIL rnd_timing[%0d]: got mov=%0d llena=%0d expected %0d/%0d", it, nm, nl, exp_m, exp_l); end
            n_tests++; if (so !== 1'b0) begin n_fail++; $display("FAIL rnd_overlap[%0d]: both pulses high", it); end
            n_tests++; if (board_diffs() !== 0) begin n_fail++; $display("FAIL rnd_board[%0d]: %0d cells differ", it, board_diffs()); end
            n_tests++; if (jugador_actual !== 2'(m_jug) || ganador !== 2'(m_gan) || empate !== m_emp || ocupado !== m_fin) begin
                n_fail++;
                $display("FAIL rnd_regs[%0d]: got jug=%b gan=%b emp=%b ocu=%b expected %0d/%0d/%0d/%0d", it, jugador_actual, ganador, empate, ocupado, m_jug, m_gan, m_emp, m_fin);
            end
            if (res == 2) do_limpiar();
        end
    endtask

    initial begin
        test_reset();
        test_single_drop();
        test_priority();
        test_full_column();
        test_ignored();
        test_win_and_clear();
        test_draw();
        test_reset_mid_move();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
